// File: rtl/osnt_bram_replay_pkg.sv
// Shared types and word-layout helpers for the UltraRAM trace load/replay sequencer.
// A memory word holds tdata, tuser, tkeep, tlast and a valid flag, LSB first.
package osnt_bram_replay_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StReplay,
        StDrain
    } state_e;

    function automatic int unsigned off_tuser(input int unsigned tdata_w);
        return tdata_w;
    endfunction

    function automatic int unsigned off_tkeep(input int unsigned tdata_w,
                                              input int unsigned tuser_w);
        return tdata_w + tuser_w;
    endfunction

    function automatic int unsigned off_tlast(input int unsigned tdata_w,
                                              input int unsigned tuser_w);
        return off_tkeep(tdata_w, tuser_w) + tdata_w / 8;
    endfunction

    function automatic int unsigned off_valid(input int unsigned tdata_w,
                                              input int unsigned tuser_w);
        return off_tlast(tdata_w, tuser_w) + 1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/osnt_bram_replay_ctrl_if.sv
// AXI-Stream bundle used for both the trace input and the replay output.
interface osnt_bram_replay_ctrl_if #(
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TUSER_WIDTH = 128
);
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;

    modport master (
        output tdata, tuser, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tuser, tkeep, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/osnt_bram_skid_fifo.sv
// Small synchronous FIFO absorbing the one-cycle memory read latency on the replay path.
// The head entry is presented combinationally; it only changes on a pop.
module osnt_bram_skid_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/osnt_bram_replay_ctrl.sv
// Single master of the packet-store memory port: LOAD writes an AXI-Stream trace,
// REPLAY streams it back N times (or forever) at one word per cycle.
module osnt_bram_replay_ctrl
    import osnt_bram_replay_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TUSER_WIDTH = 128,
    parameter int unsigned DATA_WIDTH  = 736,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                    bram_clk,
    input  logic                    bram_rst,
    input  logic                    start_load,
    input  logic                    start_replay,
    input  logic                    stop,
    input  logic [31:0]             replay_count,
    output logic                    busy,
    output logic [ADDR_WIDTH:0]     stored_words,
    output logic [31:0]             replays_done,
    output logic                    load_overflow,
    osnt_bram_replay_ctrl_if.slave  s_axis,
    osnt_bram_replay_ctrl_if.master m_axis,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wrdata,
    input  logic [DATA_WIDTH-1:0]   bram_rddata,
    output logic                    bram_en,
    output logic                    bram_we
);
    localparam int unsigned KeepW    = TDATA_WIDTH / 8;
    localparam int unsigned OffTuser = off_tuser(TDATA_WIDTH);
    localparam int unsigned OffTkeep = off_tkeep(TDATA_WIDTH, TUSER_WIDTH);
    localparam int unsigned OffTlast = off_tlast(TDATA_WIDTH, TUSER_WIDTH);
    localparam int unsigned OffValid = off_valid(TDATA_WIDTH, TUSER_WIDTH);
    localparam int unsigned FifoW    = OffTlast + 1;
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     last_eop_q, last_eop_d;
    logic [ADDR_WIDTH:0]     stored_words_q, stored_words_d;
    logic                    load_overflow_q, load_overflow_d;
    logic [31:0]             replays_done_q, replays_done_d;
    logic [31:0]             replay_count_q, replay_count_d;
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic                    inflight_q, inflight_d;
    logic                    stop_pending_q, stop_pending_d;
    logic                    discard_q, discard_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic                    s_tready, s_hs;
    logic                    rd_issue;
    logic [ADDR_WIDTH:0]     rd_ptr_next;
    logic                    fifo_push, fifo_pop, fifo_valid;
    logic [FifoW-1:0]        fifo_rdata;
    logic [CntW-1:0]         fifo_count;
    logic [CntW:0]           occ;
    logic                    issue_room;
    logic                    ret_tlast;
    logic                    unused_rd;

    // Full is exactly wr_ptr == 2**ADDR_WIDTH, i.e. the extra MSB set.
    assign s_tready    = (state_q == StLoad) && !wr_ptr_q[ADDR_WIDTH];
    assign s_hs        = s_axis.tvalid && s_tready;
    assign rd_ptr_next = rd_ptr_q + 1'b1;

    // A returned word is only valid in the cycle after its read enable.
    assign fifo_push  = inflight_q && !discard_q;
    assign fifo_pop   = fifo_valid && m_axis.tready;
    assign ret_tlast  = bram_rddata[OffTlast];
    assign occ        = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q}
                        - {{CntW{1'b0}}, fifo_pop};
    assign issue_room = (occ < (CntW + 1)'(FIFO_DEPTH));

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        last_eop_d      = last_eop_q;
        stored_words_d  = stored_words_q;
        load_overflow_d = load_overflow_q;
        replays_done_d  = replays_done_q;
        replay_count_d  = replay_count_q;
        rd_ptr_d        = rd_ptr_q;
        stop_pending_d  = stop_pending_q;
        discard_d       = discard_q;
        inflight_d      = 1'b0;
        rd_issue        = 1'b0;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;

        unique case (state_q)
            StIdle: begin
                stop_pending_d = 1'b0;
                discard_d      = 1'b0;
                if (start_load) begin
                    state_d         = StLoad;
                    wr_ptr_d        = '0;
                    last_eop_d      = '0;
                    load_overflow_d = 1'b0;
                end else if (start_replay && (stored_words_q != '0)) begin
                    state_d        = StReplay;
                    rd_ptr_d       = '0;
                    replays_done_d = '0;
                    replay_count_d = replay_count;
                end
            end
            StLoad: begin
                if (s_hs) begin
                    wr_en_d                                = 1'b1;
                    wr_addr_d                              = wr_ptr_q[ADDR_WIDTH-1:0];
                    wr_data_d                              = '0;
                    wr_data_d[TDATA_WIDTH-1:0]             = s_axis.tdata;
                    wr_data_d[OffTuser +: TUSER_WIDTH]     = s_axis.tuser;
                    wr_data_d[OffTkeep +: KeepW]           = s_axis.tkeep;
                    wr_data_d[OffTlast]                    = s_axis.tlast;
                    wr_data_d[OffValid]                    = 1'b1;
                    wr_ptr_d                               = wr_ptr_q + 1'b1;
                    if (s_axis.tlast) begin
                        last_eop_d = wr_ptr_d;
                    end
                    if (wr_ptr_d[ADDR_WIDTH]) begin
                        load_overflow_d = 1'b1;
                    end
                end
                // Only whole packets survive: a trailing partial packet is dropped.
                if (stop) begin
                    stored_words_d = last_eop_d;
                    state_d        = StIdle;
                end
            end
            StReplay: begin
                if (stop) begin
                    stop_pending_d = 1'b1;
                end
                if (fifo_push && ret_tlast && (stop || stop_pending_q)) begin
                    discard_d = 1'b1;
                    state_d   = StDrain;
                end else if (issue_room) begin
                    rd_issue   = 1'b1;
                    inflight_d = 1'b1;
                    if (rd_ptr_next == stored_words_q) begin
                        rd_ptr_d       = '0;
                        replays_done_d = sat_inc32(replays_done_q);
                        if ((replay_count_q != '0) && (replays_done_d >= replay_count_q)) begin
                            state_d = StDrain;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_next;
                    end
                end
            end
            StDrain: begin
                if ((fifo_count == '0) && !inflight_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge bram_clk) begin
        if (bram_rst) begin
            state_q         <= StIdle;
            wr_ptr_q        <= '0;
            last_eop_q      <= '0;
            stored_words_q  <= '0;
            load_overflow_q <= 1'b0;
            replays_done_q  <= '0;
            replay_count_q  <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            stop_pending_q  <= 1'b0;
            discard_q       <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            last_eop_q      <= last_eop_d;
            stored_words_q  <= stored_words_d;
            load_overflow_q <= load_overflow_d;
            replays_done_q  <= replays_done_d;
            replay_count_q  <= replay_count_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= inflight_d;
            stop_pending_q  <= stop_pending_d;
            discard_q       <= discard_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
        end
    end

    osnt_bram_skid_fifo #(
        .WIDTH (FifoW),
        .DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clk_i   (bram_clk),
        .rst_i   (bram_rst),
        .push_i  (fifo_push),
        .wdata_i (bram_rddata[FifoW-1:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    // Reads are issued combinationally so a single in-flight word keeps line rate;
    // writes never coincide with reads since they only follow a LOAD handshake.
    assign bram_en     = wr_en_q | rd_issue;
    assign bram_we     = wr_en_q;
    assign bram_addr   = wr_en_q ? wr_addr_q : rd_ptr_q[ADDR_WIDTH-1:0];
    assign bram_wrdata = wr_data_q;

    assign s_axis.tready = s_tready;
    assign m_axis.tvalid = fifo_valid;
    assign m_axis.tdata  = fifo_rdata[TDATA_WIDTH-1:0];
    assign m_axis.tuser  = fifo_rdata[OffTuser +: TUSER_WIDTH];
    assign m_axis.tkeep  = fifo_rdata[OffTkeep +: KeepW];
    assign m_axis.tlast  = fifo_rdata[OffTlast];

    assign busy          = (state_q != StIdle);
    assign stored_words  = stored_words_q;
    assign replays_done  = replays_done_q;
    assign load_overflow = load_overflow_q;

    assign unused_rd = ^bram_rddata[DATA_WIDTH-1:FifoW];

endmodule

// File: tb/tb_osnt_bram_replay_ctrl.sv
// Scoreboard bench for the trace load/replay sequencer with a 16-word memory model.
module tb_osnt_bram_replay_ctrl;
    localparam int unsigned AW  = 4;
    localparam int unsigned TDW = 32;
    localparam int unsigned TUW = 8;
    localparam int unsigned DW  = 48;
    localparam int unsigned FD  = 2;

    typedef logic [44:0] beat_t; // {tlast, tkeep, tuser, tdata}

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load = 1'b0, start_replay = 1'b0, stop = 1'b0;
    logic [31:0]   replay_count = '0;
    logic          busy, load_overflow, bram_en, bram_we;
    logic [AW:0]   stored_words;
    logic [31:0]   replays_done;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata, bram_rddata;

    always #5 clk = ~clk;

    osnt_bram_replay_ctrl_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) s_if ();
    osnt_bram_replay_ctrl_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) m_if ();

    osnt_bram_replay_ctrl #(
        .ADDR_WIDTH (AW),
        .TDATA_WIDTH(TDW),
        .TUSER_WIDTH(TUW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .bram_clk     (clk),
        .bram_rst     (rst),
        .start_load   (start_load),
        .start_replay (start_replay),
        .stop         (stop),
        .replay_count (replay_count),
        .busy         (busy),
        .stored_words (stored_words),
        .replays_done (replays_done),
        .load_overflow(load_overflow),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .bram_addr    (bram_addr),
        .bram_wrdata  (bram_wrdata),
        .bram_rddata  (bram_rddata),
        .bram_en      (bram_en),
        .bram_we      (bram_we)
    );

    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wrdata;
            else         bram_rddata    <= mem[bram_addr];
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          pop_cyc[$];
    beat_t       exp_q[$];
    logic [51:0] wr_q[$];
    beat_t       pend[$];
    beat_t       trace[$];
    beat_t       cur_beat, prev_beat;
    bit          prev_stall = 1'b0;
    bit          last_tlast = 1'b0;
    int          gidx = 0;
    int          wr_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every output handshake and every memory write.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur_beat = {m_if.tlast, m_if.tkeep, m_if.tuser, m_if.tdata};
            if (prev_stall) chk("stall_hold", {18'd0, m_if.tvalid, cur_beat}, {18'd0, 1'b1, prev_beat});
            if (m_if.tvalid && m_if.tready) begin
                n_out++;
                pop_cyc.push_back(cyc);
                last_tlast = m_if.tlast;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur_beat);
                end else begin
                    chk("out_beat", {19'd0, cur_beat}, {19'd0, exp_q.pop_front()});
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = cur_beat;
            if (bram_en && bram_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             bram_addr, bram_wrdata);
                end else begin
                    chk("bram_write", {12'd0, bram_addr, bram_wrdata}, {12'd0, wr_q.pop_front()});
                end
            end
        end
    end

    function automatic beat_t mkbeat(input int idx, input bit last);
        logic [31:0] d;
        d = 32'h5A00_0000 + 32'(idx) * 32'h0001_0203;
        return {last, (last ? 4'h7 : 4'hF), 8'(idx * 7 + 3), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input beat_t b, output bit ok, output int waited);
        s_if.tdata  = b[31:0];
        s_if.tuser  = b[39:32];
        s_if.tkeep  = b[43:40];
        s_if.tlast  = b[44];
        s_if.tvalid = 1'b1;
        waited = 0;
        while (!s_if.tready && waited < 6) begin
            tick();
            waited++;
        end
        ok = s_if.tready;
        if (ok) begin
            wr_q.push_back({4'(wr_cnt), 3'b001, b});
            wr_cnt++;
            pend.push_back(b);
            tick();
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, inout int stalls);
        bit ok;
        int w;
        for (int i = 0; i < len; i++) begin
            send_beat(mkbeat(gidx, i == len - 1), ok, w);
            gidx++;
            stalls += w + (ok ? 0 : 1);
        end
    endtask

    task automatic do_start_load();
        wr_cnt = 0;
        pend.delete();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_start_replay(input logic [31:0] cnt);
        replay_count = cnt;
        start_replay = 1'b1;
        tick();
        start_replay = 1'b0;
    endtask

    // Only the prefix ending at the last tlast is kept as the stored trace.
    task automatic commit_trace();
        int last = -1;
        foreach (pend[i]) if (pend[i][44]) last = i;
        trace.delete();
        for (int i = 0; i <= last; i++) trace.push_back(pend[i]);
    endtask

    task automatic push_passes(input int n);
        for (int p = 0; p < n; p++) foreach (trace[i]) exp_q.push_back(trace[i]);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int stalls;
        int base;
        int n;
        bit ok;
        int w;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_stored", stored_words, 0);
        chk("rst_replays", replays_done, 0);
        chk("rst_overflow", load_overflow, 0);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_bram_ctl", {bram_en, bram_we}, 0);
        chk("rst_bram_addr_data", {bram_addr, bram_wrdata}, 0);

        do_start_replay(32'd1);
        chk("replay_empty_stays_idle", busy, 0);

        // Load 4/2/5-beat packets.
        do_start_load();
        chk("t1_busy", busy, 1);
        stalls = 0;
        send_pkt(4, stalls);
        send_pkt(2, stalls);
        send_pkt(5, stalls);
        chk("t1_tready_stalls", stalls, 0);
        do_stop();
        commit_trace();
        chk("t1_stored", stored_words, 11);
        chk("t1_idle", busy, 0);
        repeat (2) tick();
        chk("t1_writes_done", wr_q.size(), 0);

        // Two passes, tready high.
        push_passes(2);
        pop_cyc.delete();
        do_start_replay(32'd2);
        n = 0;
        while (pop_cyc.size() < 22 && n < 200) begin
            tick();
            n++;
        end
        chk("t2_beats", pop_cyc.size(), 22);
        if (pop_cyc.size() == 22) chk("t2_span", pop_cyc[21] - pop_cyc[0], 21);
        chk("t2_replays", replays_done, 2);
        wait_idle(3, "t2_busy_low");
        chk("t2_queue_empty", exp_q.size(), 0);

        // Same replay under alternating backpressure.
        push_passes(2);
        do_start_replay(32'd2);
        n = 0;
        while (busy && n < 300) begin
            tick();
            m_if.tready = ~m_if.tready;
            n++;
        end
        m_if.tready = 1'b1;
        chk("t3_idle", busy, 0);
        chk("t3_queue_empty", exp_q.size(), 0);
        chk("t3_replays", replays_done, 2);

        // Overflow: 10-beat packet plus 6 beats fill the 16-word store.
        do_start_load();
        stalls = 0;
        send_pkt(10, stalls);
        for (int i = 0; i < 6; i++) begin
            send_beat(mkbeat(gidx, 1'b0), ok, w);
            gidx++;
            stalls += w + (ok ? 0 : 1);
        end
        chk("t4_stalls", stalls, 0);
        s_if.tvalid = 1'b1;
        chk("t4_tready_low", s_if.tready, 0);
        chk("t4_overflow", load_overflow, 1);
        tick();
        chk("t4_tready_still_low", s_if.tready, 0);
        s_if.tvalid = 1'b0;
        do_stop();
        commit_trace();
        chk("t4_stored", stored_words, 10);
        chk("t4_overflow_sticky", load_overflow, 1);
        repeat (2) tick();
        chk("t4_writes_done", wr_q.size(), 0);

        // Infinite replay of 3+4 beat trace, stopped early in pass 2 packet 2.
        do_start_load();
        chk("t5_overflow_cleared", load_overflow, 0);
        stalls = 0;
        send_pkt(3, stalls);
        send_pkt(4, stalls);
        do_stop();
        commit_trace();
        chk("t5_stored", stored_words, 7);
        push_passes(2);
        base = n_out;
        do_start_replay(32'd0);
        n = 0;
        while (n_out < base + 11 && n < 200) begin
            tick();
            n++;
        end
        do_stop();
        wait_idle(50, "t5_idle");
        chk("t5_beats", n_out - base, 14);
        chk("t5_last_tlast", last_tlast, 1);
        chk("t5_queue_empty", exp_q.size(), 0);
        repeat (5) tick();
        chk("t5_no_extra", n_out - base, 14);

        // Reset in the middle of a replay.
        push_passes(3);
        base = n_out;
        do_start_replay(32'd0);
        n = 0;
        while (n_out < base + 3 && n < 200) begin
            tick();
            n++;
        end
        chk("t6_tvalid_before", m_if.tvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("t6_m_tvalid", m_if.tvalid, 0);
        chk("t6_bram_en", bram_en, 0);
        chk("t6_stored", stored_words, 0);
        chk("t6_replays", replays_done, 0);
        do_start_replay(32'd1);
        repeat (2) tick();
        chk("t6_stays_idle", busy, 0);
        chk("t6_no_reads", bram_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
